// File: rtl/assert_pkg.sv
// Shared types and default widths for the assertion event arbiter.
package assert_pkg;

  localparam int unsigned N_REQ_DEF  = 5;
  localparam int unsigned CODE_W_DEF = 8;
  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned SEQ_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned SRC_W_DEF  = $clog2(N_REQ_DEF);

  // One buffered assertion event, laid out in FIFO packing order (src first, seq last).
  typedef struct packed {
    logic [SRC_W_DEF-1:0]  src;
    logic [CODE_W_DEF-1:0] code;
    logic [XLEN_DEF-1:0]   pc;
    logic                  fatal;
    logic [SEQ_W_DEF-1:0]  seq;
  } assert_evt_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with registered storage, full/empty flags and occupancy count.
module evt_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Overflow/underflow requests are ignored rather than corrupting the pointers.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; depth is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/assert_event_arbiter.sv
// Round-robin arbiter sharing one log channel between pipeline check points, with
// fatal-event drain-and-halt sequencing.
module assert_event_arbiter
  import assert_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned CODE_W = CODE_W_DEF,
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned SEQ_W  = SEQ_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*CODE_W-1:0]   req_code,
  input  logic [N_REQ*XLEN-1:0]     req_pc,
  input  logic [N_REQ-1:0]          req_fatal,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [$clog2(N_REQ)-1:0]  log_src,
  output logic [CODE_W-1:0]         log_code,
  output logic [XLEN-1:0]           log_pc,
  output logic                      log_fatal,
  output logic [SEQ_W-1:0]          log_seq,
  output logic                      halt,
  output logic                      draining
);

  localparam int unsigned SrcW = $clog2(N_REQ);
  localparam int unsigned EvtW = SrcW + CODE_W + XLEN + 1 + SEQ_W;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  arb_state_e        state_q;
  logic [SrcW-1:0]   rr_ptr_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [N_REQ-1:0]  grant;
  logic [SrcW-1:0]   grant_idx;
  logic              accept, pop;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [EvtW-1:0]   fifo_rdata;
  logic [SrcW-1:0]   h_src;
  logic [CODE_W-1:0] h_code;
  logic [XLEN-1:0]   h_pc;
  logic              h_fatal;
  logic [SEQ_W-1:0]  h_seq;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  function automatic logic [N_REQ-1:0] rr_grant(input logic [N_REQ-1:0] valid,
                                                 input logic [SrcW-1:0]  ptr);
    logic [N_REQ-1:0] rot, pick;
    rot  = N_REQ'({valid, valid} >> ptr);
    pick = rot & (~rot + N_REQ'(1));
    return N_REQ'(({pick, pick} << ptr) >> N_REQ);
  endfunction

  // Grant only while running with a free slot; a same-cycle pop does not count as free.
  always_comb begin
    grant = '0;
    if (state_q == ST_RUN && !fifo_full) grant = rr_grant(req_valid, rr_ptr_q);
  end

  // One-hot grant to requester index.
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = SrcW'(i);
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign log_valid = ~fifo_empty;
  assign pop       = log_valid & log_ready;

  evt_fifo #(
    .Width (EvtW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i ({grant_idx, req_code[grant_idx*CODE_W +: CODE_W],
               req_pc[grant_idx*XLEN +: XLEN], req_fatal[grant_idx], seq_q}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {h_src, h_code, h_pc, h_fatal, h_seq} = fifo_rdata;

  // Head fields are forced to zero when nothing is queued so stale storage never leaks out.
  always_comb begin
    log_src   = log_valid ? h_src   : '0;
    log_code  = log_valid ? h_code  : '0;
    log_pc    = log_valid ? h_pc    : '0;
    log_fatal = log_valid ? h_fatal : 1'b0;
    log_seq   = log_valid ? h_seq   : '0;
  end

  // Round-robin pointer and acceptance sequence counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      seq_q    <= '0;
    end else if (accept) begin
      rr_ptr_q <= (grant_idx == SrcW'(N_REQ - 1)) ? '0 : grant_idx + SrcW'(1);
      seq_q    <= seq_q + SEQ_W'(1);
    end
  end

  // Stop sequencing: a fatal accept starts the drain, the final pop lands in halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:   if (accept && req_fatal[grant_idx]) state_q <= ST_DRAIN;
        ST_DRAIN: if (pop && fifo_count == CntW'(1)) state_q <= ST_HALT;
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign halt     = (state_q == ST_HALT);
  assign draining = (state_q == ST_DRAIN);

endmodule
